// File: rtl/mig_request_arbiter.sv
// Arbitrates the MIG app command/write-data port between one credit-throttled
// display read stream and N_WR round-robin pixel-write requesters.
module mig_request_arbiter #(
  parameter int N_WR            = 2,
  parameter int ADDR_W          = 28,
  parameter int DATA_W          = 128,
  parameter int CNT_W           = 9,
  parameter int FIFO_LOW        = 100,
  parameter int FIFO_HIGH       = 200,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_grant,
  input  logic [N_WR-1:0]            wr_req,
  input  logic [N_WR*ADDR_W-1:0]     wr_addr,
  input  logic [N_WR*DATA_W-1:0]     wr_data,
  input  logic [N_WR*DATA_W/8-1:0]   wr_mask,
  output logic [N_WR-1:0]            wr_grant,
  input  logic [CNT_W-1:0]           fifo_level,
  input  logic                       app_rdy,
  input  logic                       app_wdf_rdy,
  input  logic                       app_rd_data_valid,
  output logic                       app_en,
  output logic [2:0]                 app_cmd,
  output logic [ADDR_W-1:0]          app_addr,
  output logic                       app_wdf_wren,
  output logic                       app_wdf_end,
  output logic [DATA_W-1:0]          app_wdf_data,
  output logic [DATA_W/8-1:0]        app_wdf_mask,
  output logic [5:0]                 outstanding,
  output logic                       credit_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int EFF_W  = CNT_W + 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    CMD_RD = 2'd1,
    CMD_WR = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;

  logic             pending_rd;
  logic             accept;
  logic             rd_accept;
  logic             load;
  logic [EFF_W-1:0] eff;
  logic [6:0]       inflight;
  logic             read_ok;
  logic             urgent;
  logic             wr_found;
  logic [PTR_W-1:0] wr_win;
  logic [PTR_W-1:0] cand;
  logic             pick_rd;
  logic             pick_wr;

  // Handshake: a command transfers on app_en & app_rdy. Writes are only
  // offered while app_wdf_rdy is high so command and data go in one cycle;
  // everything presented stays frozen until that transfer happens.
  assign pending_rd   = (state == CMD_RD);
  assign app_en       = pending_rd | ((state == CMD_WR) & app_wdf_rdy);
  assign accept       = app_en & app_rdy;
  assign rd_accept    = accept & pending_rd;
  assign app_wdf_wren = accept & (state == CMD_WR);
  assign app_wdf_end  = app_wdf_wren;
  assign load         = (state == EMPTY) | accept;

  // A loaded but unaccepted read already counts against the credit budget.
  assign eff      = {1'b0, fifo_level} + EFF_W'(outstanding) + EFF_W'(pending_rd);
  assign inflight = {1'b0, outstanding} + {6'd0, pending_rd};
  assign read_ok  = rd_req & (eff < EFF_W'(FIFO_HIGH)) & (inflight < 7'(MAX_OUTSTANDING));
  assign urgent   = (eff <= EFF_W'(FIFO_LOW));

  always_comb begin
    wr_found = 1'b0;
    wr_win   = '0;
    cand     = '0;
    for (int i = 0; i < N_WR; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % N_WR);
      if (!wr_found && wr_req[cand]) begin
        wr_found = 1'b1;
        wr_win   = cand;
      end
    end
  end

  assign pick_rd  = (read_ok & urgent) | (!wr_found & read_ok);
  assign pick_wr  = !(read_ok & urgent) & wr_found;
  assign rd_grant = load & pick_rd & !rst;

  always_comb begin
    wr_grant = '0;
    if (load && pick_wr && !rst) wr_grant[wr_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      rr_ptr       <= '0;
      app_cmd      <= 3'b001;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      outstanding  <= '0;
      credit_err   <= 1'b0;
    end else begin
      if (load) begin
        if (pick_rd) begin
          state    <= CMD_RD;
          app_cmd  <= 3'b001;
          app_addr <= rd_addr;
        end else if (pick_wr) begin
          state        <= CMD_WR;
          app_cmd      <= 3'b000;
          app_addr     <= wr_addr[int'(wr_win)*ADDR_W +: ADDR_W];
          app_wdf_data <= wr_data[int'(wr_win)*DATA_W +: DATA_W];
          app_wdf_mask <= wr_mask[int'(wr_win)*MASK_W +: MASK_W];
          rr_ptr       <= PTR_W'((int'(wr_win) + 1) % N_WR);
        end else begin
          state <= EMPTY;
        end
      end

      if (rd_accept && !app_rd_data_valid) begin
        outstanding <= outstanding + 6'd1;
      end else if (!rd_accept && app_rd_data_valid && outstanding != 6'd0) begin
        outstanding <= outstanding - 6'd1;
      end
      // Returned data with no credit in flight means the MIG and our count disagree.
      if (app_rd_data_valid && outstanding == 6'd0) credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_request_arbiter.sv
// Bench for mig_request_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model and an address scoreboard.
module tb_mig_request_arbiter;

  localparam int N_WR      = 2;
  localparam int ADDR_W    = 28;
  localparam int DATA_W    = 128;
  localparam int CNT_W     = 9;
  localparam int FIFO_LOW  = 100;
  localparam int FIFO_HIGH = 200;
  localparam int MAX_OUT   = 32;
  localparam int MASK_W    = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     rd_req;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_grant;
  logic [N_WR-1:0]          wr_req;
  logic [N_WR*ADDR_W-1:0]   wr_addr;
  logic [N_WR*DATA_W-1:0]   wr_data;
  logic [N_WR*MASK_W-1:0]   wr_mask;
  logic [N_WR-1:0]          wr_grant;
  logic [CNT_W-1:0]         fifo_level;
  logic                     app_rdy;
  logic                     app_wdf_rdy;
  logic                     app_rd_data_valid;
  logic                     app_en;
  logic [2:0]               app_cmd;
  logic [ADDR_W-1:0]        app_addr;
  logic                     app_wdf_wren;
  logic                     app_wdf_end;
  logic [DATA_W-1:0]        app_wdf_data;
  logic [MASK_W-1:0]        app_wdf_mask;
  logic [5:0]               outstanding;
  logic                     credit_err;

  // clock / reset
  always #5 clk = ~clk;

  mig_request_arbiter #(
    .N_WR(N_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .FIFO_LOW(FIFO_LOW), .FIFO_HIGH(FIFO_HIGH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_grant(wr_grant), .fifo_level(fifo_level),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .outstanding(outstanding), .credit_err(credit_err)
  );

  int num_checks = 0;
  int num_errors = 0;

  // scoreboard: addresses granted, in the order they must reach the MIG
  logic [ADDR_W-1:0] exp_q[$];

  // reference model: the command slot (0 none, 1 read, 2 write) and credit count
  int                m_kind;
  int                m_ptr;
  int                m_out;
  bit                m_err;
  logic [2:0]        m_cmd;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [MASK_W-1:0] m_mask;

  logic              seen_rd_grant;
  logic [N_WR-1:0]   seen_wr_grant;
  logic [N_WR-1:0]   exp_wr_grant;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_ptr = 0; m_out = 0; m_err = 1'b0;
    m_cmd = 3'b001; m_addr = '0; m_data = '0; m_mask = '0;
  endtask

  task automatic new_payload();
    rd_addr = ADDR_W'($urandom);
    for (int i = 0; i < N_WR; i++) begin
      wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      wr_mask[i*MASK_W +: MASK_W] = MASK_W'($urandom);
    end
    for (int i = 0; i < N_WR*DATA_W/32; i++) wr_data[i*32 +: 32] = $urandom;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the model
  // across the following posedge, and returns at the next negedge.
  task automatic cycle();
    int infl, eff, win, choice, j;
    bit rok, urg, e_en, e_acc, ld, inc, dec;
    logic [N_WR-1:0] e_wg;
    #1;
    infl = m_out + ((m_kind == 1) ? 1 : 0);
    eff  = int'(fifo_level) + infl;
    rok  = rd_req && (eff < FIFO_HIGH) && (infl < MAX_OUT);
    urg  = (eff <= FIFO_LOW);
    e_en  = (m_kind == 1) || (m_kind == 2 && app_wdf_rdy);
    e_acc = e_en && app_rdy;
    ld    = (m_kind == 0) || e_acc;
    win = -1;
    for (int k = 0; k < N_WR; k++) begin
      j = (m_ptr + k) % N_WR;
      if (win < 0 && wr_req[j]) win = j;
    end
    choice = 0;
    if (ld && !rst) begin
      if (rok && urg) choice = 1;
      else if (win >= 0) choice = 2;
      else if (rok) choice = 1;
    end
    e_wg = '0;
    if (choice == 2) e_wg[win] = 1'b1;

    check("app_en", app_en, e_en);
    check("app_cmd", app_cmd, m_cmd);
    check("app_addr", app_addr, m_addr);
    check("app_wdf_wren", app_wdf_wren, e_acc && m_kind == 2);
    check("app_wdf_end", app_wdf_end, e_acc && m_kind == 2);
    check("app_wdf_data", app_wdf_data, m_data);
    check("app_wdf_mask", app_wdf_mask, m_mask);
    check("rd_grant", rd_grant, choice == 1);
    check("wr_grant", wr_grant, e_wg);
    check("outstanding", outstanding, m_out);
    check("credit_err", credit_err, m_err);
    seen_rd_grant = rd_grant;
    seen_wr_grant = wr_grant;
    exp_wr_grant  = e_wg;

    if (e_acc) begin
      if (exp_q.size() == 0) begin
        num_checks++;
        num_errors++;
        $display("FAIL sb_order: command accepted at addr %0h with nothing granted", app_addr);
      end else begin
        check("sb_order", app_addr, exp_q.pop_front());
      end
    end

    if (rst) begin
      exp_q.delete();
      model_reset();
    end else begin
      if (choice == 1) exp_q.push_back(rd_addr);
      if (choice == 2) exp_q.push_back(wr_addr[win*ADDR_W +: ADDR_W]);
      inc = e_acc && (m_kind == 1);
      dec = app_rd_data_valid;
      if (dec && m_out == 0) m_err = 1'b1;
      if (inc && !dec) m_out++;
      else if (dec && !inc && m_out > 0) m_out--;
      if (ld) begin
        if (choice == 1) begin
          m_kind = 1; m_cmd = 3'b001; m_addr = rd_addr;
        end else if (choice == 2) begin
          m_kind = 2; m_cmd = 3'b000;
          m_addr = wr_addr[win*ADDR_W +: ADDR_W];
          m_data = wr_data[win*DATA_W +: DATA_W];
          m_mask = wr_mask[win*MASK_W +: MASK_W];
          m_ptr  = (win + 1) % N_WR;
        end else begin
          m_kind = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  // Return every credit and empty the command slot, bounded.
  task automatic drain();
    rd_req = 1'b0; wr_req = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int g = 0; g < 100; g++) begin
      if (m_out == 0 && m_kind == 0) break;
      app_rd_data_valid = (m_out > 0);
      cycle();
    end
    app_rd_data_valid = 1'b0;
    check("drain_outstanding", outstanding, 0);
    check("drain_idle", app_en, 0);
  endtask

  int               cnt;
  int               first_wr_cycle;
  logic [N_WR-1:0]  first_wg;
  logic [DATA_W-1:0] saved_data;
  logic [ADDR_W-1:0] saved_addr;
  int               fl;

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = '0; wr_addr = '0;
    wr_data = '0; wr_mask = '0; fifo_level = '0; app_rdy = 1'b1;
    app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // 1: low fill, reads only: 32 credits then stall until data returns
    fifo_level = 9'd50; rd_req = 1'b1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      new_payload(); cycle(); cnt += int'(seen_rd_grant);
    end
    check("t1_rd_grants", cnt, MAX_OUT);
    check("t1_outstanding", outstanding, MAX_OUT);
    check("t1_stalled", app_en, 0);
    app_rd_data_valid = 1'b1; cycle();
    check("t1_no_grant_at_full", seen_rd_grant, 0);
    app_rd_data_valid = 1'b0; cycle();
    check("t1_grant_after_return", seen_rd_grant, 1);
    drain();

    // 2: mid fill, both writers held: strict alternation, reads wait
    fifo_level = 9'd150; rd_req = 1'b1; wr_req = 2'b11; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      new_payload(); cycle();
      check("t2_wr_order", seen_wr_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      cnt += int'(seen_rd_grant);
    end
    check("t2_no_reads", cnt, 0);
    wr_req = '0; new_payload(); cycle();
    check("t2_read_after", seen_rd_grant, 1);
    drain();

    // 3: urgent fill: reads win until eff passes FIFO_LOW
    fifo_level = 9'd90; rd_req = 1'b1; wr_req = 2'b01; cnt = 0;
    first_wr_cycle = -1; first_wg = '0;
    for (int i = 0; i < 20; i++) begin
      new_payload(); cycle();
      if (first_wr_cycle < 0 && seen_wr_grant != '0) begin
        first_wr_cycle = i; first_wg = seen_wr_grant;
      end
      if (first_wr_cycle < 0) cnt += int'(seen_rd_grant);
    end
    check("t3_reads_first", cnt, FIFO_LOW - 90 + 1);
    check("t3_wr_cycle", first_wr_cycle, FIFO_LOW - 90 + 1);
    check("t3_wr0", first_wg, 2'b01);
    drain();

    // 4: write held off by app_wdf_rdy
    rd_req = 1'b0; wr_req = 2'b01; app_wdf_rdy = 1'b0; new_payload();
    saved_data = wr_data[DATA_W-1:0];
    cycle();
    check("t4_grant", seen_wr_grant, 2'b01);
    wr_req = '0;
    for (int i = 0; i < 5; i++) begin
      new_payload(); cycle();
      check("t4_en_low", app_en, 0);
      check("t4_wren_low", app_wdf_wren, 0);
      check("t4_data_stable", app_wdf_data, saved_data);
    end
    app_wdf_rdy = 1'b1; #1;
    check("t4_en", app_en, 1);
    check("t4_wren", app_wdf_wren, 1);
    check("t4_end", app_wdf_end, 1);
    cycle();
    drain();

    // 5: read held off by app_rdy
    fifo_level = 9'd50; rd_req = 1'b1; app_rdy = 1'b0; new_payload();
    saved_addr = rd_addr;
    cycle();
    check("t5_grant", seen_rd_grant, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      new_payload(); cycle();
      cnt += int'(seen_rd_grant);
      check("t5_addr_stable", app_addr, saved_addr);
      check("t5_out_hold", outstanding, 0);
    end
    check("t5_no_grant", cnt, 0);
    drain();

    // 6: spurious return, then reset in the middle of a pending read
    app_rd_data_valid = 1'b1; cycle();
    app_rd_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("t6_credit_err", credit_err, 1);
    check("t6_out_zero", outstanding, 0);
    fifo_level = 9'd50; rd_req = 1'b1; app_rdy = 1'b0; cycle();
    rd_req = 1'b0; rst = 1'b1; cycle();
    rst = 1'b0; app_rdy = 1'b1; #1;
    check("t6_rst_en", app_en, 0);
    check("t6_rst_cmd", app_cmd, 3'b001);
    check("t6_rst_addr", app_addr, 0);
    check("t6_rst_data", app_wdf_data, 0);
    check("t6_rst_mask", app_wdf_mask, 0);
    check("t6_rst_out", outstanding, 0);
    check("t6_rst_err", credit_err, 0);
    check("t6_rst_grants", {rd_grant, wr_grant}, 0);
    cycle();

    // random traffic around the thresholds
    fl = 120;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) fl = $urandom_range(0, 300);
      else fl = fl + $urandom_range(0, 8) - 4;
      if (fl < 0) fl = 0;
      if (fl > 300) fl = 300;
      fifo_level = CNT_W'(fl);
      rd_req = ($urandom_range(0, 3) != 0);
      wr_req = wr_req & ~exp_wr_grant;
      for (int k = 0; k < N_WR; k++) if ($urandom_range(0, 9) < 3) wr_req[k] = 1'b1;
      app_rdy = ($urandom_range(0, 4) != 0);
      app_wdf_rdy = ($urandom_range(0, 4) != 0);
      app_rd_data_valid = (m_out > 0) && ($urandom_range(0, 9) < 4);
      new_payload();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
